// File: rtl/chunker_pkg.sv
// chunker_pkg: shared helpers for the word-to-chunk streaming block.
// Chunk-count function, level width helper, bit-order codes, stage states.
package chunker_pkg;

   localparam int MSB_FIRST = 0;
   localparam int LSB_FIRST = 1;

   typedef enum logic {
      EMPTY  = 1'b0,
      STREAM = 1'b1
   } stage_t;

   function automatic int nr(input int l, input int m);
      return l / m;
   endfunction

   function automatic int lvl_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/chunker_stream_if.sv
// chunker_stream_if: word input and chunk output handshakes.
// slave is the chunker side, master is the producer/consumer side.
interface chunker_stream_if #(
   parameter int L = 8,
   parameter int M = 2
);

   logic [L-1:0] data_in;
   logic         in_valid;
   logic         in_ready;
   logic [M-1:0] q;
   logic         valid;
   logic         out_ready;

   modport master (
      output data_in, in_valid, out_ready,
      input  in_ready, q, valid
   );

   modport slave (
      input  data_in, in_valid, out_ready,
      output in_ready, q, valid
   );

endinterface

// File: rtl/chunker_stream_sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count.
// Push while full and pop while empty are ignored.
module sync_fifo
   import chunker_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int CW = lvl_w(DEPTH),
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // storage write, no reset needed on data
   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= din;
   end

   // pointer and occupancy bookkeeping
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= nxt(wr_ptr);
         if (do_pop)
            rd_ptr <= nxt(rd_ptr);
         if (do_push && !do_pop)
            count <= count + CW'(1);
         else if (do_pop && !do_push)
            count <= count - CW'(1);
      end
   end

endmodule

// File: rtl/chunker_stream.sv
// chunker_stream: buffers L-bit words and emits them as M-bit chunks.
// Full FIFO drops input and sets a sticky overflow flag.
module chunker_stream
   import chunker_pkg::*;
#(
   parameter int L         = 8,
   parameter int M         = 2,
   parameter int DEPTH     = 4,
   parameter int LSB_FIRST = 0
) (
   input  logic                       clk,
   input  logic                       reset,
   chunker_stream_if.slave            bus,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic                       overflow
);

   localparam int NR = nr(L, M);
   localparam int IW = (NR > 1) ? $clog2(NR) : 1;

   if (M < 1 || M > L) begin : g_bad_m
      $error("chunker_stream: M must satisfy 1 <= M <= L");
   end else if (L % M != 0) begin : g_bad_lm
      $error("chunker_stream: L must be a multiple of M");
   end
   if (DEPTH < 1) begin : g_bad_depth
      $error("chunker_stream: DEPTH must be >= 1");
   end

   stage_t        state;
   logic [L-1:0]  word;
   logic [IW-1:0] idx;
   logic [M-1:0]  q_r;
   logic          valid_r;

   logic [L-1:0]  head;
   logic          fifo_full;
   logic          fifo_empty;
   logic          push;
   logic          pop_fire;
   logic          last;
   logic          load;

   function automatic logic [M-1:0] pick(
      input logic [L-1:0] w,
      input int           i
   );
      logic [L-1:0] s;
      int           sel;
      sel = (LSB_FIRST == chunker_pkg::LSB_FIRST) ? i : (NR - 1 - i);
      s   = w >> (sel * M);
      return s[M-1:0];
   endfunction

   assign bus.in_ready = !fifo_full && !reset;
   assign bus.q        = q_r;
   assign bus.valid    = valid_r;

   assign push     = bus.in_valid && bus.in_ready;
   assign pop_fire = valid_r && bus.out_ready;
   assign last     = (idx == IW'(NR - 1));
   assign load     = !fifo_empty &&
                     ((state == EMPTY) || (pop_fire && last));

   sync_fifo #(
      .WIDTH (L),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (load),
      .din   (bus.data_in),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (level)
   );

   // output stage FSM: load, advance, reload or drain to empty
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= EMPTY;
         word    <= '0;
         idx     <= '0;
         q_r     <= '0;
         valid_r <= 1'b0;
      end else begin
         unique case (state)
            EMPTY: begin
               if (load) begin
                  word    <= head;
                  idx     <= '0;
                  q_r     <= pick(head, 0);
                  valid_r <= 1'b1;
                  state   <= STREAM;
               end
            end
            STREAM: begin
               if (pop_fire) begin
                  if (!last) begin
                     idx <= idx + IW'(1);
                     q_r <= pick(word, int'(idx) + 1);
                  end else if (load) begin
                     word <= head;
                     idx  <= '0;
                     q_r  <= pick(head, 0);
                  end else begin
                     idx     <= '0;
                     valid_r <= 1'b0;
                     state   <= EMPTY;
                  end
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

   // sticky flag for words refused because the FIFO was full
   always_ff @(posedge clk) begin
      if (reset)
         overflow <= 1'b0;
      else if (bus.in_valid && fifo_full)
         overflow <= 1'b1;
   end

endmodule

// File: tb/tb_chunker_stream.sv
// tb_chunker_stream: scoreboard bench over four chunker configurations.
// A: MSB-first, B: LSB-first, C: DEPTH=2, D: M=8 (one chunk per word).
module tb_chunker_stream;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   chunker_stream_if #(.L(8), .M(2)) ifa ();
   chunker_stream_if #(.L(8), .M(2)) ifb ();
   chunker_stream_if #(.L(8), .M(2)) ifc ();
   chunker_stream_if #(.L(8), .M(8)) ifd ();

   logic [2:0] level_a, level_b, level_d;
   logic [1:0] level_c;
   logic       ovf_a, ovf_b, ovf_c, ovf_d;

   chunker_stream #(.L(8), .M(2), .DEPTH(4), .LSB_FIRST(0)) dut_a (
      .clk(clk), .reset(reset), .bus(ifa), .level(level_a), .overflow(ovf_a));
   chunker_stream #(.L(8), .M(2), .DEPTH(4), .LSB_FIRST(1)) dut_b (
      .clk(clk), .reset(reset), .bus(ifb), .level(level_b), .overflow(ovf_b));
   chunker_stream #(.L(8), .M(2), .DEPTH(2), .LSB_FIRST(0)) dut_c (
      .clk(clk), .reset(reset), .bus(ifc), .level(level_c), .overflow(ovf_c));
   chunker_stream #(.L(8), .M(8), .DEPTH(4), .LSB_FIRST(0)) dut_d (
      .clk(clk), .reset(reset), .bus(ifd), .level(level_d), .overflow(ovf_d));

   logic [7:0] din  [4];
   logic       iv   [4];
   logic       ordy [4];
   logic [7:0] qv   [4];
   logic       vv   [4];
   logic       ir   [4];
   logic [7:0] lv   [4];
   logic       ov   [4];

   assign ifa.data_in = din[0];
   assign ifb.data_in = din[1];
   assign ifc.data_in = din[2];
   assign ifd.data_in = din[3];
   assign ifa.in_valid = iv[0];
   assign ifb.in_valid = iv[1];
   assign ifc.in_valid = iv[2];
   assign ifd.in_valid = iv[3];
   assign ifa.out_ready = ordy[0];
   assign ifb.out_ready = ordy[1];
   assign ifc.out_ready = ordy[2];
   assign ifd.out_ready = ordy[3];

   assign qv[0] = {6'b0, ifa.q};
   assign qv[1] = {6'b0, ifb.q};
   assign qv[2] = {6'b0, ifc.q};
   assign qv[3] = ifd.q;
   assign vv[0] = ifa.valid;
   assign vv[1] = ifb.valid;
   assign vv[2] = ifc.valid;
   assign vv[3] = ifd.valid;
   assign ir[0] = ifa.in_ready;
   assign ir[1] = ifb.in_ready;
   assign ir[2] = ifc.in_ready;
   assign ir[3] = ifd.in_ready;
   assign lv[0] = {5'b0, level_a};
   assign lv[1] = {5'b0, level_b};
   assign lv[2] = {6'b0, level_c};
   assign lv[3] = {5'b0, level_d};
   assign ov[0] = ovf_a;
   assign ov[1] = ovf_b;
   assign ov[2] = ovf_c;
   assign ov[3] = ovf_d;

   logic [7:0] expq [4][$];
   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // expected chunk stream of one word for DUT d
   task automatic push_word(input int d, input logic [7:0] w);
      int m, n, sel;
      logic [7:0] s;
      m = (d == 3) ? 8 : 2;
      n = 8 / m;
      for (int i = 0; i < n; i++) begin
         sel = (d == 1) ? i : (n - 1 - i);
         s = w >> (sel * m);
         expq[d].push_back((m == 8) ? s : (s & 8'h03));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // score every chunk taken by the consumer
   always @(negedge clk) begin
      if (!reset) begin
         for (int d = 0; d < 4; d++) begin
            if (vv[d] && ordy[d]) begin
               if (expq[d].size() == 0)
                  check($sformatf("unexpected_valid_%0d", d), 32'(vv[d]), 0);
               else
                  check($sformatf("chunk_%0d", d), 32'(qv[d]),
                        32'(expq[d].pop_front()));
            end
         end
      end
   end

   initial begin
      logic [7:0] w1;
      reset = 1'b1;
      for (int d = 0; d < 4; d++) begin
         din[d]  = '0;
         iv[d]   = 1'b0;
         ordy[d] = 1'b1;
      end
      tick();
      tick();
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
         check($sformatf("rst_in_ready_%0d", d), 32'(ir[d]), 0);
         check($sformatf("rst_valid_%0d", d), 32'(vv[d]), 0);
         check($sformatf("rst_q_%0d", d), 32'(qv[d]), 0);
         check($sformatf("rst_level_%0d", d), 32'(lv[d]), 0);
         check($sformatf("rst_ovf_%0d", d), 32'(ov[d]), 0);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      for (int d = 0; d < 4; d++)
         check($sformatf("post_rst_in_ready_%0d", d), 32'(ir[d]), 1);

      // single word, MSB-first on A and LSB-first on B
      for (int d = 0; d < 2; d++) begin
         din[d] = 8'b01101011;
         iv[d]  = 1'b1;
         push_word(d, 8'b01101011);
      end
      tick();
      iv[0] = 1'b0;
      iv[1] = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("single_valid_a", 32'(vv[0]), 1);
         check("single_valid_b", 32'(vv[1]), 1);
         tick();
      end
      @(negedge clk);
      check("single_done_a", 32'(vv[0]), 0);
      check("single_done_b", 32'(vv[1]), 0);
      tick();

      // back-to-back words on A, no bubble
      din[0] = 8'h6B;
      iv[0]  = 1'b1;
      push_word(0, 8'h6B);
      tick();
      din[0] = 8'hA5;
      push_word(0, 8'hA5);
      tick();
      iv[0] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("b2b_valid", 32'(vv[0]), 1);
         tick();
      end
      @(negedge clk);
      check("b2b_done", 32'(vv[0]), 0);
      check("b2b_level", 32'(lv[0]), 0);
      tick();

      // one chunk per word on D
      iv[3] = 1'b1;
      din[3] = 8'h11;
      push_word(3, 8'h11);
      tick();
      din[3] = 8'h22;
      push_word(3, 8'h22);
      tick();
      din[3] = 8'h33;
      push_word(3, 8'h33);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("nr1_valid", 32'(vv[3]), 1);
         tick();
         iv[3] = 1'b0;
      end
      @(negedge clk);
      check("nr1_done", 32'(vv[3]), 0);
      tick();

      // backpressure and overflow on C (DEPTH=2)
      ordy[2] = 1'b0;
      iv[2] = 1'b1;
      din[2] = 8'h6B;
      push_word(2, 8'h6B);
      tick();
      din[2] = 8'hA5;
      push_word(2, 8'hA5);
      tick();
      din[2] = 8'h3C;
      push_word(2, 8'h3C);
      tick();
      din[2] = 8'hFF;
      @(negedge clk);
      check("full_in_ready", 32'(ir[2]), 0);
      tick();
      iv[2] = 1'b0;
      w1 = 8'h6B >> 6;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_level", 32'(lv[2]), 2);
         check("bp_overflow", 32'(ov[2]), 1);
         check("bp_valid", 32'(vv[2]), 1);
         check("bp_hold_q", 32'(qv[2]), 32'(w1));
         tick();
      end
      ordy[2] = 1'b1;
      for (int i = 0; i < 40 && (expq[2].size() != 0 || vv[2]); i++)
         tick();
      check("bp_drain", 32'(expq[2].size()), 0);
      @(negedge clk);
      check("bp_drain_valid", 32'(vv[2]), 0);
      tick();

      // reset after the second chunk of a word on A
      din[0] = 8'h6B;
      iv[0]  = 1'b1;
      push_word(0, 8'h6B);
      tick();
      iv[0] = 1'b0;
      tick();
      tick();
      tick();
      reset = 1'b1;
      expq[0].delete();
      din[1] = 8'h5A;
      iv[1]  = 1'b1;
      tick();
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
         check($sformatf("mid_rst_valid_%0d", d), 32'(vv[d]), 0);
         check($sformatf("mid_rst_q_%0d", d), 32'(qv[d]), 0);
         check($sformatf("mid_rst_level_%0d", d), 32'(lv[d]), 0);
         check($sformatf("mid_rst_ovf_%0d", d), 32'(ov[d]), 0);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      iv[1] = 1'b0;
      for (int i = 0; i < 10; i++)
         tick();
      @(negedge clk);
      check("post_rst_idle_a", 32'(vv[0]), 0);
      check("post_rst_idle_b", 32'(vv[1]), 0);
      check("post_rst_ovf_b", 32'(ov[1]), 0);
      for (int d = 0; d < 4; d++)
         check($sformatf("leftover_%0d", d), 32'(expq[d].size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/chunker_stream.md
# chunker_stream

- Parametrised successor to `chunker_with_buffer`.
- Accepts L-bit words through a valid/ready handshake and buffers up to DEPTH of them in a word FIFO.
- Emits each word as NR = L/M consecutive M-bit chunks, with selectable bit order and output backpressure.
- Sits between the raw-bit sampler and the Toeplitz hashing core, so input words arriving faster than they are consumed are held rather than lost.
- Words offered while the FIFO is full are dropped and flagged.

## Interface

Parameters:
- `L`, 8: input word width in bits. Must be a multiple of M; elaboration fails otherwise.
- `M`, 2: chunk width in bits, 1 ≤ M ≤ L.
- `DEPTH`, 4: word FIFO depth, ≥ 1. Does not include the output stage.
- `LSB_FIRST`, 0: chunk order. 0 = most-significant chunk first; 1 = least-significant chunk first.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `data_in`  in  L  input word
- `in_valid`  in  1  `data_in` is offered this cycle
- `in_ready`  out  1  FIFO can accept a word this cycle
- `q`  out  M  current chunk
- `valid`  out  1  `q` holds a valid chunk
- `out_ready`  in  1  consumer takes `q` this cycle
- `level`  out  $clog2(DEPTH+1)  FIFO occupancy, in words
- `overflow`  out  1  sticky: a word was offered while `in_ready` was 0

One clock; reset is synchronous and active-high.

## Operation

- **Accept:** a word is written to the FIFO tail at an edge where `in_valid && in_ready`.
- **`in_ready`:** equals `!full && !reset`. It does not depend on a same-cycle pop, so a full FIFO refuses input even while popping.
- **Drop:** `in_valid && !in_ready && !reset` discards the word and sets `overflow`. `overflow` clears only on reset.
- **Output stage:** holds one word, a chunk index `idx` in 0..NR-1, and an `occupied` flag. `valid` = `occupied`.
  - `LSB_FIRST=0`: `q` = `word[(NR-1-idx)*M +: M]`.
  - `LSB_FIRST=1`: `q` = `word[idx*M +: M]`.
- **Advance:** at an edge with `valid && out_ready`, `idx` increments. On the last chunk (`idx == NR-1`):
  - the stage reloads from the FIFO head if the FIFO is non-empty, `idx` → 0;
  - otherwise `occupied` → 0.
- **Idle load:** when `!occupied` and the FIFO is non-empty, the stage loads the head at the next edge.
- **Hold:** with `valid && !out_ready`, `q`, `idx` and the word are held unchanged.
- **Stage states:** EMPTY (`occupied=0`) and STREAM (`occupied=1`, `idx` 0..NR-1).
  - EMPTY → STREAM on a load.
  - STREAM → EMPTY on the last-chunk pop with the FIFO empty.
  - STREAM → STREAM (reload) on the last-chunk pop with the FIFO non-empty.
- **`level`:** +1 on accept, −1 on stage load. Both in one cycle leave it unchanged.
- **Degenerate case M = L (NR = 1):** every pop is a last-chunk pop.

## Timing

- **Reset values:** `valid=0`, `q=0`, `idx=0`, `level=0`, `overflow=0`, FIFO empty. `in_ready=0` during reset and 1 in the first cycle after.
- **Reset mid-word:** the partial word, FIFO contents and any in-flight accept are discarded. A word offered in the reset cycle is not accepted and does not set `overflow`.
- **Latency:** word accepted at edge k into an empty block, then loaded at edge k+1. Its first chunk is on `q` with `valid=1` after edge k+1 (2 edges).
- **Throughput:** with `out_ready=1` and a non-empty FIFO, consecutive words stream with no bubble, one chunk per cycle.
- **Registered outputs:** `q`, `valid`, `level` and `overflow` are registered. `in_ready` is a combinational function of the full flag and `reset`.
- **Accept and load in one cycle:**
  - empty FIFO: the FIFO never falls through in the same edge;
  - full FIFO: the load frees a slot only for the following cycle.

## Structure

- **Package `chunker_pkg`:** function `nr(L,M)`, the width helper for `level`, and the bit-order localparams `MSB_FIRST=0` / `LSB_FIRST=1`.
- **Sub-module `sync_fifo`:** parametrised (WIDTH, DEPTH) with push, pop, full, empty and count. It is reusable by other blocks.
- **Top level:** `chunker_stream` implements the output stage, the drop/overflow logic and the parameter assertions.

## Test plan

- **MSB-first:** L=8, M=2, LSB_FIRST=0, one word 8'b01101011, `out_ready=1` → `q` = 01, 10, 10, 11 on 4 consecutive cycles starting 2 edges after accept, then `valid=0`.
- **LSB-first:** same word with LSB_FIRST=1 → `q` = 11, 10, 10, 01.
- **Back-to-back:** words 8'h6B then 8'hA5 on consecutive cycles, `out_ready=1` → 8 contiguous valid chunks 01,10,10,11,10,10,01,01, no bubble, `level` returns to 0.
- **Backpressure and full:** DEPTH=2, `out_ready=0`, offer 4 words.
  - Word 1 goes to the stage, words 2–3 fill the FIFO, `level=2`, `in_ready=0`.
  - Word 4 is dropped and `overflow=1`.
  - `q` holds the first chunk throughout.
  - Releasing `out_ready` yields 12 chunks of words 1–3 only.
- **Reset mid-word:** assert `reset` after the 2nd chunk of 8'h6B → next cycle `valid=0`, `q=0`, `level=0`, `overflow=0`, and no stale chunk appears afterwards.
- **NR=1:** M=8, words 8'h11, 8'h22, 8'h33 back-to-back → `q` = 11, 22, 33 on consecutive cycles.
